// File: rtl/sync_monostable.sv
// sync_monostable: clock-synchronous multi-channel 423-style one-shot
// Ports:
//   clk, reset   system clock, synchronous active-high reset
//   _a, b        per-channel trigger inputs; a channel fires when (!_a && b) becomes true
//   _r           per-channel active-low synchronous clear
//   width        per-channel pulse width in clocks, channel n at [n*WB +: WB]
//   q, _q        pulse output and its complement
//   busy         channel is timing its delay or pulse
//   missed       sticky flag: trigger arrived while busy with retriggering disabled
module sync_monostable #(
    parameter int CHANNELS     = 4,
    parameter int WB           = 8,
    parameter int DELAY_CYCLES = 1,
    parameter int RETRIGGER    = 0,
    parameter int TRUNCATE     = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [CHANNELS-1:0]    _a,
    input  logic [CHANNELS-1:0]    b,
    input  logic [CHANNELS-1:0]    _r,
    input  logic [CHANNELS*WB-1:0] width,
    output logic [CHANNELS-1:0]    q,
    output logic [CHANNELS-1:0]    _q,
    output logic [CHANNELS-1:0]    busy,
    output logic [CHANNELS-1:0]    missed
);
    typedef enum logic [1:0] {IDLE, DELAY, PULSE} state_t;
    localparam logic [WB-1:0] DLY = WB'(DELAY_CYCLES);
    localparam logic [WB-1:0] ONE = WB'(1);
    for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
        state_t        r_st;
        logic [WB-1:0] r_cnt;
        logic [WB-1:0] r_wlat;
        logic          r_cond_d;
        logic          r_missed;
        logic [WB-1:0] w_w;
        logic          w_cond;
        logic          w_ev;
        logic          w_go;
        assign w_w    = width[n*WB +: WB];
        assign w_cond = !_a[n] && b[n];
        assign w_ev   = w_cond && !r_cond_d;
        // zero-width events never start or restart a pulse
        assign w_go   = w_ev && (w_w != '0);
        always_ff @(posedge clk) begin
            if (reset) begin
                r_st     <= IDLE;
                r_cnt    <= '0;
                r_wlat   <= '0;
                r_cond_d <= 1'b1;
                r_missed <= 1'b0;
            end else begin
                r_cond_d <= w_cond;
                if (!_r[n]) begin
                    r_st     <= IDLE;
                    r_cnt    <= '0;
                    r_missed <= 1'b0;
                end else if (TRUNCATE != 0 && !w_cond && r_st != IDLE) begin
                    r_st  <= IDLE;
                    r_cnt <= '0;
                end else if (w_go && (r_st == IDLE || RETRIGGER != 0)) begin
                    // a retrigger in PULSE extends without re-running the delay
                    r_wlat <= w_w;
                    if (r_st == PULSE || DELAY_CYCLES == 0) begin
                        r_st  <= PULSE;
                        r_cnt <= w_w;
                    end else begin
                        r_st  <= DELAY;
                        r_cnt <= DLY;
                    end
                end else begin
                    if (w_ev && r_st != IDLE && RETRIGGER == 0)
                        r_missed <= 1'b1;
                    if (r_st == DELAY) begin
                        r_st  <= (r_cnt == ONE) ? PULSE : DELAY;
                        r_cnt <= (r_cnt == ONE) ? r_wlat : r_cnt - ONE;
                    end else if (r_st == PULSE) begin
                        r_st  <= (r_cnt == ONE) ? IDLE : PULSE;
                        r_cnt <= r_cnt - ONE;
                    end
                end
            end
        end
        assign q[n]      = (r_st == PULSE);
        assign _q[n]     = ~q[n];
        assign busy[n]   = (r_st != IDLE);
        assign missed[n] = r_missed;
    end
endmodule
